// File: rtl/fifo.sv
// Synchronous FIFO with registered read data; a write into a full FIFO overwrites the oldest entry.
// Define FIFO_OVERFLOW_FLAG_EN to add a sticky 'overflow' output that records any such overwrite.
module fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
`ifdef FIFO_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_read;
  logic             overwrite;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_read   = rd_en && !empty;
  assign overwrite = wr_en && full && !rd_en;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset && wr_en)
      mem[wr_ptr] <= data_in;
  end

  // An overwrite drops the oldest entry by pushing the read pointer along with the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= next_ptr(wr_ptr);
      if (do_read || overwrite)
        rd_ptr <= next_ptr(rd_ptr);
      if (do_read)
        data_out <= mem[rd_ptr];
      if (wr_en && !do_read && !full)
        count <= count + 1'b1;
      else if (do_read && !wr_en)
        count <= count - 1'b1;
    end
  end

`ifdef FIFO_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (overwrite)
      overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo (DEPTH=4, WIDTH=16): directed vector table, a wrap/overwrite
// sequence, and randomized traffic compared against a queue-based reference model.
module tb_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
`ifdef FIFO_OVERFLOW_FLAG_EN
  logic             overflow;
`endif

  int error_count = 0;
  int check_count = 0;

  // Reference model: a plain queue holding stored words oldest-first.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_dout = '0;
  logic             model_ovf  = 1'b0;

  typedef struct {
    logic             rst;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_full;
    logic             exp_empty;
  } vec_t;

  vec_t vectors[$];

  fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
`ifdef FIFO_OVERFLOW_FLAG_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic updateModel(input logic rst, input logic wr, input logic rd,
                             input logic [WIDTH-1:0] din);
    if (rst) begin
      model_q.delete();
      model_dout = '0;
      model_ovf  = 1'b0;
    end else begin
      logic was_full;
      was_full = (model_q.size() == DEPTH);
      if (rd && model_q.size() > 0)
        model_dout = model_q.pop_front();
      if (wr) begin
        if (was_full && !rd) begin
          void'(model_q.pop_front());
          model_ovf = 1'b1;
        end
        model_q.push_back(din);
      end
    end
  endtask

  task automatic checkModel();
    checkOutput("model_data_out", data_out, model_dout);
    checkOutput("model_full", WIDTH'(full), WIDTH'(model_q.size() == DEPTH));
    checkOutput("model_empty", WIDTH'(empty), WIDTH'(model_q.size() == 0));
`ifdef FIFO_OVERFLOW_FLAG_EN
    checkOutput("model_overflow", WIDTH'(overflow), WIDTH'(model_ovf));
`endif
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic applyStimulus(input logic rst, input logic wr, input logic rd,
                               input logic [WIDTH-1:0] din);
    reset   = rst;
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    @(posedge clk);
    updateModel(rst, wr, rd, din);
    #1;
    checkModel();
  endtask

  function automatic vec_t mk(input logic rst, input logic wr, input logic rd,
                              input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] dout,
                              input logic f, input logic e);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.din = din;
    v.exp_dout = dout; v.exp_full = f; v.exp_empty = e;
    return v;
  endfunction

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    #2;

    // Directed scenarios with expectations written out by hand.
    vectors.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1));
    vectors.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 1));
    vectors.push_back(mk(0, 1, 0, 16'hAAAA, 16'h0000, 0, 0));
    vectors.push_back(mk(0, 1, 0, 16'hBBBB, 16'h0000, 0, 0));
    vectors.push_back(mk(0, 1, 0, 16'hCCCC, 16'h0000, 0, 0));
    vectors.push_back(mk(0, 1, 0, 16'hDDDD, 16'h0000, 1, 0));
    vectors.push_back(mk(0, 1, 0, 16'hEEEE, 16'h0000, 1, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'hBBBB, 0, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'hCCCC, 0, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'hDDDD, 0, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'hEEEE, 0, 1));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'hEEEE, 0, 1));
    vectors.push_back(mk(0, 1, 1, 16'h1234, 16'hEEEE, 0, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'h1234, 0, 1));
    vectors.push_back(mk(0, 1, 0, 16'h1111, 16'h1234, 0, 0));
    vectors.push_back(mk(0, 1, 0, 16'h2222, 16'h1234, 0, 0));
    vectors.push_back(mk(0, 1, 0, 16'h3333, 16'h1234, 0, 0));
    vectors.push_back(mk(0, 1, 0, 16'h4444, 16'h1234, 1, 0));
    vectors.push_back(mk(0, 1, 1, 16'h5555, 16'h1111, 1, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'h2222, 0, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'h3333, 0, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'h4444, 0, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'h5555, 0, 1));
    vectors.push_back(mk(0, 1, 0, 16'hABCD, 16'h5555, 0, 0));
    vectors.push_back(mk(0, 1, 0, 16'hBCDE, 16'h5555, 0, 0));
    vectors.push_back(mk(1, 1, 0, 16'h9999, 16'h0000, 0, 1));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 0, 1));
    vectors.push_back(mk(0, 1, 0, 16'h7777, 16'h0000, 0, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0000, 16'h7777, 0, 1));

    foreach (vectors[i]) begin
      applyStimulus(vectors[i].rst, vectors[i].wr, vectors[i].rd, vectors[i].din);
      checkOutput($sformatf("vec%0d_data_out", i), data_out, vectors[i].exp_dout);
      checkOutput($sformatf("vec%0d_full", i), WIDTH'(full), WIDTH'(vectors[i].exp_full));
      checkOutput($sformatf("vec%0d_empty", i), WIDTH'(empty), WIDTH'(vectors[i].exp_empty));
    end

    // Two consecutive overwrites wrap the pointers; survivors are words 3..6.
    applyStimulus(1, 0, 0, '0);
    for (int k = 1; k <= 6; k++)
      applyStimulus(0, 1, 0, WIDTH'(k));
    checkOutput("wrap_full", WIDTH'(full), 16'd1);
`ifdef FIFO_OVERFLOW_FLAG_EN
    checkOutput("wrap_overflow", WIDTH'(overflow), 16'd1);
`endif
    for (int k = 3; k <= 6; k++) begin
      applyStimulus(0, 0, 1, '0);
      checkOutput($sformatf("wrap_read%0d", k), data_out, WIDTH'(k));
    end
    checkOutput("wrap_empty", WIDTH'(empty), 16'd1);

    // Randomized traffic against the reference model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, WIDTH'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, number of storage entries (integer >= 2, not required to be a power of two).
REQ-002 The module SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port wr_en, input, 1 bit: write request for the current cycle.
REQ-006 The module SHALL have port rd_en, input, 1 bit: read request for the current cycle.
REQ-007 The module SHALL have port data_in, input, WIDTH bits: word to write.
REQ-008 The module SHALL have port data_out, output, WIDTH bits: registered read data.
REQ-009 The module SHALL have port full, output, 1 bit: high when the occupancy count equals DEPTH.
REQ-010 The module SHALL have port empty, output, 1 bit: high when the occupancy count equals 0.

Function
REQ-011 The FIFO SHALL keep a write pointer, a read pointer (both 0..DEPTH-1, wrapping DEPTH-1 -> 0) and an occupancy count 0..DEPTH.
REQ-012 full and empty SHALL be combinational decodes of the count, reflecting state after the most recent edge.
REQ-013 A write (wr_en=1, not full) SHALL store data_in at the write pointer, advance it, and increment count.
REQ-014 A read (rd_en=1, not empty) SHALL load the entry at the read pointer into data_out on that edge (1-cycle latency), advance the read pointer, and decrement count.
REQ-015 A read while empty SHALL be ignored: data_out holds its previous value, pointers and count unchanged.
REQ-016 Write while full without read (overwrite) SHALL store data_in at the write pointer, advance both pointers, and leave count at DEPTH, discarding the oldest entry.
REQ-017 Write and read together while full SHALL perform a normal read of the oldest entry plus a normal write; count stays DEPTH, no data is lost.
REQ-018 Write and read together when neither full nor empty SHALL perform both; count unchanged.
REQ-019 Write and read together while empty SHALL perform only the write; data_out holds, count becomes 1.
REQ-020 data_out SHALL change only on a successful read or reset.

Reset
REQ-021 When reset is high at a rising edge, pointers and count SHALL clear to 0, data_out SHALL clear to 0, giving empty=1, full=0.
REQ-022 Reset SHALL take priority over wr_en/rd_en in the same cycle; storage contents need not be cleared.
REQ-023 Reset asserted mid-operation SHALL discard all stored entries; the next write after reset is the oldest entry.

Configuration
REQ-024 With macro FIFO_OVERFLOW_FLAG_EN defined, the module SHALL add output overflow (1 bit), set sticky on any overwrite of REQ-016 and cleared only by reset (reset value 0).
REQ-025 Without FIFO_OVERFLOW_FLAG_EN, the overflow port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 Reset for 2 cycles -> empty=1, full=0, data_out=0000.
REQ-027 DEPTH=4: write AAAA,BBBB,CCCC,DDDD -> full=1 after 4th edge; then write EEEE -> full stays 1, AAAA discarded (overflow=1 if enabled).
REQ-028 Continuing: rd_en=1 for 5 cycles -> data_out BBBB, CCCC, DDDD, EEEE, then holds EEEE with empty=1.
REQ-029 Full FIFO (1111..4444), wr_en=rd_en=1 with 5555 -> data_out=1111, full stays 1, subsequent reads 2222,3333,4444,5555.
REQ-030 Empty FIFO, wr_en=rd_en=1 with 1234 -> data_out unchanged, empty=0, next read returns 1234.
REQ-031 Two entries stored, reset asserted with wr_en=1 -> empty=1, data_out=0000, nothing written.
